// File: rtl/fifo_d0_reader.sv
// Read-side controller for the d0 FIFO: pops into a 3-entry skid buffer
// and presents words downstream through a valid/ready handshake.
module fifo_d0_reader #(
  parameter int DATA_SIZE = 6,
  parameter int COUNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable_rd,
  input  logic                 fifo_empty_d0_cond,
  input  logic [DATA_SIZE-1:0] data_out_0_cond,
  input  logic                 fifo_error_d0,
  input  logic                 ready_in,
  output logic                 pop_d0,
  output logic                 valid_out,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [COUNT_W-1:0]   pop_count,
  output logic                 rd_error
);

  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_SIZE-1:0] buf_q [3];
  logic [DATA_SIZE-1:0] buf_d [3];
  logic [COUNT_W-1:0]   pop_count_q, pop_count_d;
  logic                 rd_error_q, rd_error_d;
  logic                 drain;
  logic                 room;
  logic                 overflow;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Room counts the in-flight word so a pop never depends on ready_in.
  assign room     = ({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3;
  assign pop_d0   = reset_L && enable_rd && !fifo_empty_d0_cond && room;
  assign valid_out = (occ_q != 2'd0);
  assign drain    = valid_out && ready_in;
  assign overflow = inflight_q && (occ_q == 2'd3) && !drain;

  assign pop_count = pop_count_q;
  assign rd_error  = rd_error_q;

  always_comb begin
    data_out = '0;
    unique case (rd_ptr_q)
      2'd0:    data_out = buf_q[0];
      2'd1:    data_out = buf_q[1];
      2'd2:    data_out = buf_q[2];
      default: data_out = '0;
    endcase
  end

  always_comb begin
    occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, drain};
    inflight_d  = pop_d0;
    wr_ptr_d    = inflight_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = drain ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    pop_count_d = pop_count_q + COUNT_W'(pop_d0);
    rd_error_d  = rd_error_q | fifo_error_d0 | overflow;
    for (int i = 0; i < 3; i++) begin
      buf_d[i] = buf_q[i];
      if (inflight_q && (wr_ptr_q == 2'(i)))
        buf_d[i] = data_out_0_cond;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_count_q <= '0;
      rd_error_q  <= 1'b0;
      for (int i = 0; i < 3; i++)
        buf_q[i] <= '0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_count_q <= pop_count_d;
      rd_error_q  <= rd_error_d;
      for (int i = 0; i < 3; i++)
        buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_fifo_d0_reader.sv
// Directed bench for fifo_d0_reader with a registered-read FIFO model.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_fifo_d0_reader;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable_rd = 1'b0;
  logic       fifo_empty;
  logic [5:0] fifo_rd = '0;
  logic       fifo_error = 1'b0;
  logic       ready_in = 1'b0;
  logic       pop_d0;
  logic       valid_out;
  logic [5:0] data_out;
  logic [7:0] pop_count;
  logic       rd_error;

  int errors = 0;
  int checks = 0;

  logic [5:0] mem [512];
  int head = 0;
  int tail = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);

  always @(posedge clk) begin
    if (pop_d0) begin
      fifo_rd <= mem[head];
      head    <= head + 1;
    end
  end

  fifo_d0_reader dut (
    .clk                (clk),
    .reset_L            (reset_L),
    .enable_rd          (enable_rd),
    .fifo_empty_d0_cond (fifo_empty),
    .data_out_0_cond    (fifo_rd),
    .fifo_error_d0      (fifo_error),
    .ready_in           (ready_in),
    .pop_d0             (pop_d0),
    .valid_out          (valid_out),
    .data_out           (data_out),
    .pop_count          (pop_count),
    .rd_error           (rd_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] v);
    mem[tail] = v;
    tail = tail + 1;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  logic [5:0] exp_q [$];
  int rcv;
  int first_v;
  int last_v;

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_pop", pop_d0, 0);
    chk("rst_count", pop_count, 0);
    chk("rst_err", rd_error, 0);
    reset_L = 1'b1;
    cyc();

    // Full throughput, 4 words
    begin
      logic [0:6] ep;
      logic [0:6] ev;
      logic [5:0] ed [7];
      ep = 7'b1111000;
      ev = 7'b0011110;
      ed = '{6'h0, 6'h0, 6'h01, 6'h02, 6'h03, 6'h04, 6'h0};
      push(6'h01); push(6'h02); push(6'h03); push(6'h04);
      enable_rd = 1'b1;
      ready_in = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("t2_pop%0d", i), pop_d0, ep[i]);
        chk($sformatf("t2_val%0d", i), valid_out, ev[i]);
        if (ev[i]) chk($sformatf("t2_dat%0d", i), data_out, ed[i]);
        cyc();
      end
      chk("t2_count", pop_count, 4);
    end

    // Backpressure: 3 pops then hold
    begin
      logic [0:5] ep;
      logic [0:5] ev;
      ep = 6'b111000;
      ev = 6'b001111;
      ready_in = 1'b0;
      push(6'h01); push(6'h02); push(6'h03); push(6'h04);
      #1;
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t3_pop%0d", i), pop_d0, ep[i]);
        chk($sformatf("t3_val%0d", i), valid_out, ev[i]);
        if (ev[i]) chk($sformatf("t3_hold%0d", i), data_out, 6'h01);
        cyc();
      end
    end
    begin
      logic [0:4] ep;
      logic [0:4] ev;
      logic [5:0] ed [5];
      ep = 5'b01000;
      ev = 5'b11110;
      ed = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h0};
      ready_in = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t3r_pop%0d", i), pop_d0, ep[i]);
        chk($sformatf("t3r_val%0d", i), valid_out, ev[i]);
        if (ev[i]) chk($sformatf("t3r_dat%0d", i), data_out, ed[i]);
        cyc();
      end
      chk("t3_count", pop_count, 8);
    end

    // enable_rd drop after first pop; 0x15 stays in the FIFO
    push(6'h2a); push(6'h15);
    #1;
    chk("t4_pop0", pop_d0, 1);
    cyc();
    enable_rd = 1'b0;
    #1;
    chk("t4_pop1", pop_d0, 0);
    chk("t4_val1", valid_out, 0);
    cyc();
    chk("t4_pop2", pop_d0, 0);
    chk("t4_val2", valid_out, 1);
    chk("t4_dat2", data_out, 6'h2a);
    cyc();
    chk("t4_val3", valid_out, 0);
    chk("t4_pop3", pop_d0, 0);
    chk("t4_count", pop_count, 9);

    // Sticky error
    fifo_error = 1'b1;
    #1;
    chk("t6_pre", rd_error, 0);
    cyc();
    fifo_error = 1'b0;
    chk("t6_set", rd_error, 1);
    cyc();
    cyc();
    chk("t6_sticky", rd_error, 1);

    // Mid-stream async reset with occ=2
    push(6'h30); push(6'h31); push(6'h32);
    ready_in = 1'b0;
    enable_rd = 1'b1;
    cyc();
    cyc();
    cyc();
    ready_in = 1'b1;
    cyc();
    chk("t1_pre_val", valid_out, 1);
    chk("t1_pre_pop", pop_d0, 1);
    reset_L = 1'b0;
    #1;
    chk("t1_val", valid_out, 0);
    chk("t1_pop", pop_d0, 0);
    chk("t1_count", pop_count, 0);
    chk("t1_err", rd_error, 0);
    chk("t1_dat", data_out, 0);
    cyc();
    reset_L = 1'b1;
    #1;
    chk("t1_pop_rel", pop_d0, 1);
    cyc();
    chk("t1_val_lat", valid_out, 0);
    cyc();
    chk("t1_val_new", valid_out, 1);
    chk("t1_dat_new", data_out, 6'h32);
    chk("t1_count_new", pop_count, 1);
    cyc();

    // 256-word stream, counter wrap
    reset_L = 1'b0;
    cyc();
    reset_L = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [5:0] v;
      v = 6'((i * 7 + 3) % 64);
      push(v);
      exp_q.push_back(v);
    end
    #1;
    rcv = 0;
    first_v = -1;
    last_v = -1;
    for (int c = 0; c < 600 && rcv < 256; c++) begin
      if (valid_out) begin
        if (data_out !== exp_q[rcv]) begin
          chk($sformatf("t5_dat%0d", rcv), data_out, exp_q[rcv]);
        end
        if (first_v < 0) first_v = c;
        last_v = c;
        rcv++;
      end
      cyc();
    end
    chk("t5_rcv", rcv, 256);
    chk("t5_gapless", last_v - first_v + 1, 256);
    chk("t5_count_wrap", pop_count, 0);
    chk("t5_err", rd_error, 0);
    chk("t5_idle", valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
